// File: rtl/fb_pkg.sv
// Shared definitions for the frame buffer read path: strobe polarity, FSM
// encoding and default widths that must agree with the frame memory.
package fb_pkg;

  // Every strobe in the frame buffer subsystem is active-low.
  localparam logic ASSERT   = 1'b0;
  localparam logic DEASSERT = 1'b1;

  localparam int FB_DATA_WIDTH = 32;
  localparam int FB_ADDR_WIDTH = 4;
  localparam int FIFO_DEPTH    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fb_state_e;

  function automatic logic strobe_on(input logic s);
    return s == ASSERT;
  endfunction

endpackage

// File: rtl/fb_skid_fifo.sv
// Two-entry FIFO between the memory read port and the pixel interface.
// push/pop/flush are active-high internal controls; rd_data is the head entry.
module fb_skid_fifo
  import fb_pkg::*;
#(
  parameter int DATA_WIDTH = FB_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [1:0]            count,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] entry_data [FIFO_DEPTH];
  logic                  wr_ptr_reg;
  logic                  rd_ptr_reg;
  logic [1:0]            count_reg;
  logic [1:0]            count_next;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count_reg == 2'd0);
  assign full    = (count_reg == 2'd2);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign do_push = push & (~full | do_pop);

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      logic [DATA_WIDTH-1:0] data_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          data_reg <= '0;
        end else if (do_push && !flush && (wr_ptr_reg == 1'(gi))) begin
          data_reg <= wr_data;
        end
      end

      assign entry_data[gi] = data_reg;
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else if (flush) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
      if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_next;
    end
  end

  assign rd_data = entry_data[rd_ptr_reg];
  assign count   = count_reg;

endmodule

// File: rtl/frame_buf_reader.sv
// Scans an address window of the frame memory and streams each word over an
// active-low valid/ready pixel interface, buffered by a two-entry skid FIFO.
module frame_buf_reader
  import fb_pkg::*;
#(
  parameter int DATA_WIDTH = FB_DATA_WIDTH,
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int MEM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_LEN = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  fb_state_e             state_reg;
  fb_state_e             state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ADDR_WIDTH:0]   rem_reg;
  logic                  pending_reg;

  logic                  start_on;
  logic                  abort_on;
  logic                  ready_on;
  logic                  start_accept;
  logic [ADDR_WIDTH:0]   len_clamped;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic                  fetch;

  logic [DATA_WIDTH-1:0] fifo_head;
  logic [1:0]            fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;

  assign start_on = strobe_on(start);
  assign abort_on = strobe_on(abort);
  assign ready_on = strobe_on(pix_ready);

  // The accepted start is held one cycle in pending_reg, so READ begins one
  // edge after the request is sampled.
  assign start_accept = (state_reg == ST_IDLE) && !pending_reg && start_on && !abort_on;
  assign len_clamped  = (length > DEPTH_LEN) ? DEPTH_LEN : length;
  assign addr_inc     = (addr_reg == LAST_ADDR) ? '0 : addr_reg + ADDR_WIDTH'(1);

  assign fifo_pop = !fifo_empty && ready_on && !abort_on;
  // Fetch whenever the word will have a slot after this edge.
  assign fetch    = (state_reg == ST_READ) && !abort_on &&
                    (!fifo_full || fifo_pop);

  fb_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fetch),
    .pop     (fifo_pop),
    .flush   (abort_on),
    .wr_data (rd_data),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_next = state_reg;
    if (abort_on) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pending_reg) begin
            state_next = (rem_reg == '0) ? ST_DONE : ST_READ;
          end
        end
        ST_READ: begin
          if (fetch && (rem_reg == (ADDR_WIDTH + 1)'(1))) begin
            state_next = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty || ((fifo_count == 2'd1) && fifo_pop)) begin
            state_next = ST_DONE;
          end
        end
        ST_DONE: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_reg <= 1'b0;
      addr_reg    <= '0;
      rem_reg     <= '0;
    end else begin
      pending_reg <= start_accept;
      if (start_accept) begin
        addr_reg <= base_addr;
        rem_reg  <= len_clamped;
      end else if (fetch) begin
        addr_reg <= addr_inc;
        rem_reg  <= rem_reg - (ADDR_WIDTH + 1)'(1);
      end
    end
  end

  assign rd_addr   = addr_reg;
  assign rd_en     = fetch ? ASSERT : DEASSERT;
  assign pix_data  = fifo_head;
  assign pix_valid = (!fifo_empty && !abort_on) ? ASSERT : DEASSERT;
  assign busy      = (state_reg != ST_IDLE) ? ASSERT : DEASSERT;
  assign done      = (state_reg == ST_DONE) ? ASSERT : DEASSERT;

endmodule

// File: tb/tb_frame_buf_reader.sv
// Directed bench for frame_buf_reader: table of frames plus hand-written
// sequences for backpressure, abort and asynchronous reset.
module tb_frame_buf_reader;
  import fb_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [3:0]  base_addr;
  logic [4:0]  length;
  logic [3:0]  rd_addr;
  logic        rd_en;
  wire  [31:0] rd_data;
  logic [31:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        busy;
  logic        done;

  logic [31:0] mem [16];
  int          n_checks;
  int          n_pass;

  assign rd_data = (rd_en == 1'b0) ? mem[rd_addr] : {32{1'bz}};

  frame_buf_reader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .length    (length),
    .rd_addr   (rd_addr),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  base;
    logic [4:0]  len;
    logic [31:0] first;
    logic [31:0] last;
    int          n;
    int          done_edge;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One frame with pix_ready held; checks every output on every cycle
  // from E1 until the cycle after the done pulse.
  task automatic run_frame(input string tag, input logic [3:0] b, input logic [4:0] l,
                           input logic [31:0] first, input logic [31:0] last,
                           input int n, input int done_edge);
    logic [31:0] exp_word;
    logic [3:0]  a;
    pix_ready = ASSERT;
    start     = ASSERT;
    base_addr = b;
    length    = l;
    tick();
    start = DEASSERT;
    for (int c = 1; c <= done_edge + 1; c++) begin
      tick();
      check($sformatf("%s c%0d busy", tag, c), busy, (c <= done_edge) ? ASSERT : DEASSERT);
      check($sformatf("%s c%0d done", tag, c), done, (c == done_edge) ? ASSERT : DEASSERT);
      check($sformatf("%s c%0d rd_en", tag, c), rd_en,
            (c >= 1 && c <= n) ? ASSERT : DEASSERT);
      if (c >= 1 && c <= n) begin
        a = b + 4'(c - 1);
        check($sformatf("%s c%0d rd_addr", tag, c), rd_addr, a);
      end
      check($sformatf("%s c%0d pix_valid", tag, c), pix_valid,
            (c >= 2 && c <= n + 1) ? ASSERT : DEASSERT);
      if (c >= 2 && c <= n + 1) begin
        a = b + 4'(c - 2);
        if (c == 2)          exp_word = first;
        else if (c == n + 1) exp_word = last;
        else                 exp_word = mem[a];
        check($sformatf("%s c%0d pix_data", tag, c), pix_data, exp_word);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pushes, pops, ahead, max_ahead, c;
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'(i) * 32'h11;

    vecs[0] = '{4'd2,  5'd4,  32'h22, 32'h55, 4,  6};
    vecs[1] = '{4'd14, 5'd4,  32'hEE, 32'h11, 4,  6};
    vecs[2] = '{4'd0,  5'd0,  32'h0,  32'h0,  0,  1};
    vecs[3] = '{4'd0,  5'd16, 32'h00, 32'hFF, 16, 18};
    vecs[4] = '{4'd3,  5'd20, 32'h33, 32'h22, 16, 18};
    vecs[5] = '{4'd15, 5'd1,  32'hFF, 32'hFF, 1,  3};

    reset     = 1'b0;
    start     = DEASSERT;
    abort     = DEASSERT;
    pix_ready = DEASSERT;
    base_addr = '0;
    length    = '0;
    #1;
    check("reset rd_en", rd_en, 1'b1);
    check("reset rd_addr", rd_addr, 4'd0);
    check("reset pix_valid", pix_valid, 1'b1);
    check("reset pix_data", pix_data, 32'h0);
    check("reset busy", busy, 1'b1);
    check("reset done", done, 1'b1);
    #11;
    reset = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      run_frame($sformatf("vec%0d", v), vecs[v].base, vecs[v].len, vecs[v].first,
                vecs[v].last, vecs[v].n, vecs[v].done_edge);
      $display("frame vec%0d base=%0d len=%0d done", v, vecs[v].base, vecs[v].len);
    end

    // Backpressure: ready dropped for cycles after E5..E8, plus an ignored
    // start arriving mid-frame.
    pushes = 0; pops = 0; max_ahead = 0;
    pix_ready = ASSERT;
    start     = ASSERT;
    base_addr = 4'd0;
    length    = 5'd8;
    tick();
    start = DEASSERT;
    c = 0;
    while (c < 60) begin
      tick();
      c++;
      pix_ready = (c >= 5 && c <= 8) ? DEASSERT : ASSERT;
      start     = (c == 3) ? ASSERT : DEASSERT;
      if (c == 3) begin
        base_addr = 4'd9;
        length    = 5'd1;
      end
      #1;
      if (done == ASSERT) break;
      ahead = pushes - pops;
      if (ahead > max_ahead) max_ahead = ahead;
      if (c >= 5 && c <= 8) begin
        check($sformatf("bp c%0d pix_data held", c), pix_data, 32'h33);
        check($sformatf("bp c%0d pix_valid held", c), pix_valid, ASSERT);
      end
      if (c >= 6 && c <= 8) check($sformatf("bp c%0d rd_en stalled", c), rd_en, DEASSERT);
      if (rd_en == ASSERT) pushes++;
      if (pix_valid == ASSERT && pix_ready == ASSERT) begin
        check($sformatf("bp pop%0d pix_data", pops), pix_data, mem[pops]);
        pops++;
      end
    end
    start = DEASSERT;
    check("bp done seen", done, ASSERT);
    check("bp words popped", 32'(pops), 32'd8);
    check("bp words fetched", 32'(pushes), 32'd8);
    check("bp max ahead", 32'(max_ahead), 32'd2);
    tick();
    check("bp idle busy", busy, DEASSERT);
    $display("frame backpressure base=0 len=8 pops=%0d", pops);

    // Abort during READ with data in the FIFO.
    start     = ASSERT;
    base_addr = 4'd0;
    length    = 5'd8;
    tick();
    start = DEASSERT;
    for (int i = 1; i <= 3; i++) tick();
    abort = ASSERT;
    #1;
    check("abort comb pix_valid", pix_valid, DEASSERT);
    check("abort comb rd_en", rd_en, DEASSERT);
    tick();
    abort = DEASSERT;
    #1;
    check("abort busy", busy, DEASSERT);
    check("abort pix_valid flushed", pix_valid, DEASSERT);
    check("abort rd_en", rd_en, DEASSERT);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("abort no done %0d", i), done, DEASSERT);
      tick();
    end
    $display("frame abort flushed");
    run_frame("post_abort", 4'd5, 5'd2, 32'h55, 32'h66, 2, 4);

    // abort wins over a simultaneous start.
    start = ASSERT;
    abort = ASSERT;
    tick();
    start = DEASSERT;
    abort = DEASSERT;
    tick();
    tick();
    check("abort_over_start busy", busy, DEASSERT);
    check("abort_over_start rd_en", rd_en, DEASSERT);
    $display("abort overrides start");

    // Asynchronous reset mid-stream, between clock edges.
    start     = ASSERT;
    base_addr = 4'd0;
    length    = 5'd8;
    tick();
    start = DEASSERT;
    for (int i = 1; i <= 4; i++) tick();
    check("pre_reset pix_valid", pix_valid, ASSERT);
    #2;
    reset = 1'b0;
    #1;
    check("async rst rd_en", rd_en, 1'b1);
    check("async rst pix_valid", pix_valid, 1'b1);
    check("async rst done", done, 1'b1);
    check("async rst busy", busy, 1'b1);
    check("async rst pix_data", pix_data, 32'h0);
    #2;
    reset = 1'b1;
    tick();
    $display("async reset mid-frame");
    run_frame("post_reset", 4'd2, 5'd4, 32'h22, 32'h55, 4, 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
